// File: rtl/ripple_count_capture_pkg.sv
// Shared definitions for the ripple-counter capture block: FSM encoding,
// default widths and a small sizing helper.
package ripple_count_capture_pkg;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_EXT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FROZEN = 2'd2
    } cap_state_t;

    // Bits needed to hold values 0..maxVal inclusive.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// Bus between the capture block and its client: raw count/control in,
// filtered count, running total and status out.
interface ripple_count_capture_if
    import ripple_count_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int EXT_W = DEF_EXT_W
);
    logic [CNT_W-1:0] f;
    logic             Enable;
    logic             Clear;
    logic [CNT_W-1:0] CountOut;
    logic             Valid;
    logic [EXT_W-1:0] Total;
    logic             Wrap;
    logic             Overflow;

    modport master (
        output f, Enable, Clear,
        input  CountOut, Valid, Total, Wrap, Overflow
    );

    modport slave (
        input  f, Enable, Clear,
        output CountOut, Valid, Total, Wrap, Overflow
    );
endinterface

// File: rtl/ripple_count_capture_count_stabilizer.sv
// Brings the asynchronous ripple count into the Clock domain bit by bit and
// reports a value only after it has been seen unchanged for STABLE_CNT samples.
module count_stabilizer
    import ripple_count_capture_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,  // must be at least 2
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [CNT_W-1:0] f,
    output logic [CNT_W-1:0] stableVal,
    output logic             stableOk
);
    localparam int RUN_W = cntWidth(STABLE_CNT);

    logic [CNT_W-1:0]       syncOut;
    logic [SYNC_STAGES-1:0] fillReg;
    logic [CNT_W-1:0]       lastReg;
    logic [RUN_W-1:0]       runReg;
    logic [RUN_W-1:0]       runNext;
    logic                   sValid;
    logic                   sameAsLast;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chainReg;
            always_ff @(posedge Clock) begin
                if (Resetn) begin
                    chainReg <= '0;
                end else begin
                    chainReg <= {chainReg[SYNC_STAGES-2:0], f[gi]};
                end
            end
            assign syncOut[gi] = chainReg[SYNC_STAGES-1];
        end
    endgenerate

    // Reset contents of the chain are not real samples; wait for it to fill.
    assign sValid     = fillReg[SYNC_STAGES-1];
    assign sameAsLast = (syncOut == lastReg);

    // runReg == 0 means "no sample yet"; otherwise it is the run length so far.
    always_comb begin
        runNext = RUN_W'(1);
        if (sameAsLast && (runReg != '0)) begin
            runNext = (runReg == RUN_W'(STABLE_CNT)) ? runReg : runReg + RUN_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            fillReg <= '0;
            lastReg <= '0;
            runReg  <= '0;
        end else begin
            fillReg <= {fillReg[SYNC_STAGES-2:0], 1'b1};
            if (sValid) begin
                lastReg <= syncOut;
                runReg  <= runNext;
            end
        end
    end

    assign stableVal = syncOut;
    assign stableOk  = sValid && (runNext >= RUN_W'(STABLE_CNT));

endmodule

// File: rtl/ripple_count_capture.sv
// Filters the ripple counter output and accumulates its increments into a wide
// total, with a wrap pulse and a sticky overflow flag.
module ripple_count_capture
    import ripple_count_capture_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int EXT_W       = DEF_EXT_W,  // must be >= CNT_W
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    ripple_count_capture_if.slave bus
);
    logic [CNT_W-1:0] stableVal;
    logic             stableOk;

    cap_state_t       stateReg;
    logic [CNT_W-1:0] countReg;
    logic             validReg;
    logic [EXT_W-1:0] totalReg;
    logic             wrapReg;
    logic             ovfReg;

    logic [CNT_W-1:0] delta;
    logic [EXT_W:0]   sumNext;
    logic             isNew;

    count_stabilizer #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT)
    ) u_stabilizer (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .f         (bus.f),
        .stableVal (stableVal),
        .stableOk  (stableOk)
    );

    // Modular difference handles the counter rolling over between accepts.
    assign delta   = stableVal - countReg;
    assign sumNext = {1'b0, totalReg} + {{(EXT_W + 1 - CNT_W){1'b0}}, delta};
    assign isNew   = stableOk && (stableVal != countReg);

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            stateReg <= ST_INIT;
            countReg <= '0;
            validReg <= 1'b0;
            totalReg <= '0;
            wrapReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else if (bus.Clear) begin
            // A value accepted this cycle is picked up again from INIT as a baseline.
            stateReg <= ST_INIT;
            totalReg <= '0;
            wrapReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else begin
            wrapReg <= 1'b0;
            unique case (stateReg)
                ST_INIT: begin
                    if (!bus.Enable) begin
                        stateReg <= ST_FROZEN;
                    end else if (stableOk) begin
                        countReg <= stableVal;
                        validReg <= 1'b1;
                        stateReg <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!bus.Enable) begin
                        stateReg <= ST_FROZEN;
                    end else if (isNew) begin
                        countReg <= stableVal;
                        totalReg <= sumNext[EXT_W-1:0];
                        wrapReg  <= (stableVal < countReg);
                        if (sumNext[EXT_W]) begin
                            ovfReg <= 1'b1;
                        end
                    end
                end
                ST_FROZEN: begin
                    // Counts seen while frozen are dropped; resume from a fresh baseline.
                    if (bus.Enable) begin
                        stateReg <= ST_INIT;
                    end
                end
                default: stateReg <= ST_INIT;
            endcase
        end
    end

    assign bus.CountOut = countReg;
    assign bus.Valid    = validReg;
    assign bus.Total    = totalReg;
    assign bus.Wrap     = wrapReg;
    assign bus.Overflow = ovfReg;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: a small model queues the expected
// output after each stimulus step and a monitor pops it when the outputs move.
module tb_ripple_count_capture;

    typedef struct {
        logic [3:0]  count;
        logic [15:0] total;
        logic        wrap;
        logic        ovf;
        logic        valid;
    } exp_t;

    logic Clock;
    logic Resetn;
    ripple_count_capture_if #(.CNT_W(4), .EXT_W(16)) bus ();

    ripple_count_capture #(
        .CNT_W(4), .EXT_W(16), .SYNC_STAGES(2), .STABLE_CNT(2)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   monOn = 1'b0;
    int   wrapSeen = 0;

    int   mCount, mTotal;
    bit   mOvf, mValid, mInit;
    int   cur;
    bit   pushed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic pushExp(input bit wrap);
        exp_t e;
        e.count = mCount[3:0];
        e.total = mTotal[15:0];
        e.wrap  = wrap;
        e.ovf   = mOvf;
        e.valid = mValid;
        q.push_back(e);
    endtask

    task automatic modelAccept(input int v, output bit didPush);
        int sum;
        bit w;
        didPush = 1'b0;
        if (mInit) begin
            didPush = (v != mCount) || !mValid;
            mCount  = v;
            mValid  = 1'b1;
            mInit   = 1'b0;
            if (didPush) pushExp(1'b0);
        end else if (v != mCount) begin
            sum = mTotal + ((v - mCount) & 15);
            if (sum > 65535) mOvf = 1'b1;
            mTotal  = sum & 16'hFFFF;
            w       = (v < mCount);
            mCount  = v;
            didPush = 1'b1;
            pushExp(w);
        end
    endtask

    task automatic modelReset();
        mInit = 1'b1; mCount = 0; mValid = 1'b0; mTotal = 0; mOvf = 1'b0;
    endtask

    task automatic stepF(input int v, input int hold);
        bit p;
        bus.f = v[3:0];
        cur   = v;
        modelAccept(v, p);
        tick(hold);
        if (p) check("drain", q.size(), 0);
    endtask

    // Monitor: any movement on the outputs must match the oldest expectation.
    initial begin
        logic [3:0]  prevCount;
        logic [15:0] prevTotal;
        logic        prevValid, prevOvf, changed;
        exp_t        e;
        prevCount = 'x; prevTotal = 'x; prevValid = 'x; prevOvf = 'x;
        forever begin
            @(negedge Clock);
            if (monOn) begin
                changed = (bus.CountOut !== prevCount) || (bus.Total !== prevTotal) ||
                          (bus.Valid !== prevValid) || (bus.Overflow !== prevOvf);
                if (bus.Wrap === 1'b1) wrapSeen++;
                if (changed) begin
                    check("pending", (q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("countOut", bus.CountOut, e.count);
                        check("total", bus.Total, e.total);
                        check("wrap", bus.Wrap, e.wrap);
                        check("overflow", bus.Overflow, e.ovf);
                        check("valid", bus.Valid, e.valid);
                        $display("txn count=%0d total=%0d wrap=%0b ovf=%0b",
                                 bus.CountOut, bus.Total, bus.Wrap, bus.Overflow);
                    end
                end else if (bus.Wrap) begin
                    check("wrapAlone", bus.Wrap, 0);
                end
            end
            prevCount = bus.CountOut; prevTotal = bus.Total;
            prevValid = bus.Valid;    prevOvf   = bus.Overflow;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit %0d", $time, 2_000_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        Resetn = 1'b1;
        bus.f = 4'd0; bus.Enable = 1'b1; bus.Clear = 1'b0;
        cur = 0;
        modelReset();
        tick(3);
        check("rstValid", bus.Valid, 0);
        check("rstTotal", bus.Total, 0);
        check("rstWrap", bus.Wrap, 0);
        check("rstOvf", bus.Overflow, 0);

        // Baseline latency: Valid must appear exactly 4 cycles after release.
        Resetn = 1'b0;
        monOn  = 1'b1;
        modelAccept(0, pushed);
        tick(3);
        check("validAt3", bus.Valid, 0);
        tick(1);
        check("validAt4", bus.Valid, 1);
        check("countAt4", bus.CountOut, 0);
        check("totalAt4", bus.Total, 0);
        tick(4);
        check("baseDrain", q.size(), 0);

        // Full sweep with one rollover.
        w0 = wrapSeen;
        for (int i = 1; i <= 16; i++) stepF(i & 15, 8);
        check("sweepTotal", bus.Total, 16);
        check("sweepWraps", wrapSeen - w0, 1);

        // Single-cycle glitches must be filtered out.
        stepF(3, 8);
        bus.f = 4'd7; tick(1);
        stepF(4, 8);
        check("glitchTotal", bus.Total, 20);

        // Increments during freeze are discarded.
        stepF(5, 8);
        bus.Enable = 1'b0; tick(1);
        bus.f = 4'd9; cur = 9; tick(8);
        check("frozenCount", bus.CountOut, 5);
        bus.Enable = 1'b1;
        mInit = 1'b1;
        modelAccept(9, pushed);
        tick(6);
        check("reenDrain", q.size(), 0);
        stepF(10, 8);
        check("enableTotal", bus.Total, 22);

        stepF(15, 8);
        stepF(9, 8);
        check("preResetTotal", bus.Total, 37);

        // Reset in the middle of operation.
        monOn = 1'b0;
        Resetn = 1'b1;
        tick(1);
        check("midRstTotal", bus.Total, 0);
        check("midRstValid", bus.Valid, 0);
        check("midRstCount", bus.CountOut, 0);
        tick(1);
        Resetn = 1'b0;
        monOn  = 1'b1;
        modelReset();
        modelAccept(cur, pushed);
        tick(8);
        check("midRstBase", bus.CountOut, 9);
        check("midRstBaseTotal", bus.Total, 0);

        // Run Total up to 0xFFFE in steps of 15, then overflow.
        for (int i = 0; i < 4368; i++) stepF((cur - 1) & 15, 6);
        stepF((cur + 14) & 15, 6);
        check("nearFull", bus.Total, 16'hFFFE);
        check("nearFullOvf", bus.Overflow, 0);
        stepF((cur + 3) & 15, 6);
        check("wrapTotal", bus.Total, 16'h0001);
        check("ovfSet", bus.Overflow, 1);
        stepF((cur + 2) & 15, 6);
        check("ovfSticky", bus.Overflow, 1);

        // Clear in the same cycle as an accept: accept becomes the new baseline.
        cur = (cur + 5) & 15;
        bus.f = cur[3:0];
        tick(3);
        bus.Clear = 1'b1;
        mTotal = 0; mOvf = 1'b0; mInit = 1'b1;
        pushExp(1'b0);
        tick(1);
        bus.Clear = 1'b0;
        modelAccept(cur, pushed);
        tick(4);
        check("clearDrain", q.size(), 0);
        check("clearTotal", bus.Total, 0);
        check("clearOvf", bus.Overflow, 0);
        check("clearBase", bus.CountOut, cur);
        stepF((cur + 1) & 15, 8);
        check("afterClear", bus.Total, 1);

        tick(4);
        check("finalQueue", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
